// File: rtl/ce_pattern_counter.sv
// ce_pattern_counter
//   Programmable clock-enable prescaler combined with a WIDTH-bit pattern
//   counter. The counter advances once per prescaler tick and shows its
//   value as binary, Gray, a rotating one-hot (ring) or a one-hot that
//   sweeps back and forth (bounce).
//
// Parameters
//   DIV    prescaler divide ratio (>= 1); CEO pulses once every DIV enabled clocks
//   WIDTH  pattern counter / output width (2..16)
//
// Ports
//   C      clock; all state changes on its rising edge
//   CLR_N  asynchronous active-low reset
//   EN     prescaler enable; low freezes the prescaler, so no ticks and no counting
//   MODE   00 binary, 01 Gray, 10 ring, 11 bounce
//   DIR    0 up/left, 1 down/right (ignored in bounce)
//   LOAD   synchronous load of D, independent of CEO
//   D      load value
//   CEO    prescaler tick, one C cycle wide
//   TC     terminal count, qualified by CEO
//   Q      pattern output
module ce_pattern_counter #(
  parameter int DIV   = 100000,
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic             CEO,
  output logic             TC,
  output logic [WIDTH-1:0] Q
);

  localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_TOP  = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  localparam logic [1:0] M_BIN  = 2'b00;
  localparam logic [1:0] M_GRAY = 2'b01;
  localparam logic [1:0] M_RING = 2'b10;

  typedef enum logic {ST_UP = 1'b0, ST_DN = 1'b1} bounce_t;

  logic [PW-1:0]    pre_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [1:0]       mode_reg;
  bounce_t          state_reg;

  logic [WIDTH-1:0] cnt_next;
  bounce_t          state_next;
  logic [WIDTH-1:0] load_val;
  bounce_t          load_state;
  logic             resync;
  logic             at_end;
  logic             bnc_up;
  logic [WIDTH-1:0] gray_val;
  logic [WIDTH-1:0] onehot_val;

  // ---------------------------------------------------------------- prescaler
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      pre_reg <= '0;
    end else if (EN) begin
      pre_reg <= (pre_reg == PRE_LAST) ? '0 : pre_reg + PW'(1);
    end
  end

  // With DIV=1 the prescaler is stuck at 0 == PRE_LAST, so CEO follows EN.
  assign CEO    = EN && (pre_reg == PRE_LAST);
  assign resync = (MODE != mode_reg);

  // ------------------------------------------------------------- load value
  // The incoming MODE decides the clamp: it equals mode_reg unless this is a
  // resync edge, where the new mode is the one the loaded value must suit.
  always_comb begin
    load_val = D;
    if (MODE[1] && (D > CNT_TOP)) begin
      load_val = CNT_TOP;
    end
    load_state = ((MODE == 2'b11) && (load_val == CNT_TOP)) ? ST_DN : ST_UP;
  end

  // ------------------------------------------------------------ step logic
  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    bnc_up     = 1'b0;
    case (mode_reg)
      M_BIN, M_GRAY: begin
        cnt_next = DIR ? cnt_reg - CNT_ONE : cnt_reg + CNT_ONE;
      end
      M_RING: begin
        if (DIR) begin
          cnt_next = (cnt_reg == '0) ? CNT_TOP : cnt_reg - CNT_ONE;
        end else begin
          cnt_next = (cnt_reg == CNT_TOP) ? '0 : cnt_reg + CNT_ONE;
        end
      end
      default: begin
        // Turn around when sitting on an end so the sweep never stalls,
        // even if the state and position ever disagree.
        bnc_up   = ((state_reg == ST_UP) && (cnt_reg != CNT_TOP)) ||
                   ((state_reg == ST_DN) && (cnt_reg == '0));
        cnt_next = bnc_up ? cnt_reg + CNT_ONE : cnt_reg - CNT_ONE;
        if (bnc_up) begin
          state_next = (cnt_next == CNT_TOP) ? ST_DN : ST_UP;
        end else begin
          state_next = (cnt_next == '0) ? ST_UP : ST_DN;
        end
      end
    endcase
  end

  // ------------------------------------------------------ terminal count
  always_comb begin
    case (mode_reg)
      M_BIN, M_GRAY: at_end = DIR ? (cnt_reg == '0) : (cnt_reg == '1);
      M_RING:        at_end = DIR ? (cnt_reg == '0) : (cnt_reg == CNT_TOP);
      default:       at_end = (state_reg == ST_DN) && (cnt_reg == CNT_ONE);
    endcase
  end

  // A pending load or resync overrides the step, so no terminal count then.
  assign TC = CEO && at_end && !LOAD && !resync;

  // ------------------------------------------------- counter / bounce FSM
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_reg   <= '0;
      mode_reg  <= M_BIN;
      state_reg <= ST_UP;
    end else if (resync) begin
      mode_reg  <= MODE;
      cnt_reg   <= LOAD ? load_val : '0;
      state_reg <= LOAD ? load_state : ST_UP;
    end else if (LOAD) begin
      cnt_reg   <= load_val;
      state_reg <= load_state;
    end else if (CEO) begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------- output decode
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
    if (gi < WIDTH - 1) begin : g_inner
      assign gray_val[gi] = cnt_reg[gi] ^ cnt_reg[gi+1];
    end else begin : g_msb
      assign gray_val[gi] = cnt_reg[gi];
    end
    assign onehot_val[gi] = (cnt_reg == WIDTH'(gi));
  end

  always_comb begin
    case (mode_reg)
      M_BIN:   Q = cnt_reg;
      M_GRAY:  Q = gray_val;
      default: Q = onehot_val;
    endcase
  end

endmodule

// File: tb/tb_ce_pattern_counter.sv
module tb_ce_pattern_counter;

  logic       C;
  logic       CLR_N;
  logic       EN;
  logic [1:0] MODE;
  logic       DIR;
  logic       LOAD;
  logic [3:0] D;
  logic       CEO;
  logic       TC;
  logic [3:0] Q;

  ce_pattern_counter #(.DIV(4), .WIDTH(4)) dut (
    .C     (C),
    .CLR_N (CLR_N),
    .EN    (EN),
    .MODE  (MODE),
    .DIR   (DIR),
    .LOAD  (LOAD),
    .D     (D),
    .CEO   (CEO),
    .TC    (TC),
    .Q     (Q)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: every CEO cycle is a transaction; Q/TC are the values seen
  // during the tick cycle (before the step lands).
  always @(negedge C) begin
    if (CLR_N && CEO) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_tick: got CEO=1 Q=%h TC=%b, required no tick", Q, TC);
      end else begin
        mon_e = exp_q.pop_front();
        if (Q !== mon_e.q || TC !== mon_e.tc) begin
          n_miss++;
          $display("FAIL %s: got Q=%b TC=%b, required Q=%b TC=%b",
                   mon_e.name, Q, TC, mon_e.q, mon_e.tc);
        end else begin
          $display("tick %s: Q=%b TC=%b", mon_e.name, Q, TC);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  task automatic push(input string name, input logic [3:0] q, input logic tc);
    exp_t e;
    e.name = name;
    e.q    = q;
    e.tc   = tc;
    exp_q.push_back(e);
  endtask

  // One full prescaler period starting from pre=0; exactly one tick inside.
  task automatic tick(input string name, input logic [3:0] q, input logic tc);
    push(name, q, tc);
    edges(4);
  endtask

  // Load pulse on the first edge of a prescaler period, then finish the period.
  task automatic load_op(input string name, input logic [3:0] d,
                         input logic [3:0] q_after, input logic tc);
    LOAD = 1'b1;
    D    = d;
    edges(1);
    LOAD = 1'b0;
    check({name, "_q"}, Q, q_after);
    push({name, "_tick"}, q_after, tc);
    edges(3);
  endtask

  // Mode change on the first edge of a prescaler period, then finish it.
  task automatic mode_op(input string name, input logic [1:0] m, input logic dir,
                         input logic [3:0] q_after);
    MODE = m;
    DIR  = dir;
    edges(1);
    check({name, "_resync_q"}, Q, q_after);
    push({name, "_tick"}, q_after, 1'b0);
    edges(3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    CLR_N = 1'b0;
    EN    = 1'b1;
    MODE  = 2'b00;
    DIR   = 1'b0;
    LOAD  = 1'b0;
    D     = 4'h0;
    #2;
    check("reset_q",   Q,            4'h0);
    check("reset_tc",  {3'b0, TC},   4'h0);
    check("reset_ceo", {3'b0, CEO},  4'h0);
    @(negedge C);
    CLR_N = 1'b1;

    // Binary up: ticks on cycles 3,7,11,15,19
    for (int i = 0; i < 5; i++) tick("bin_up", 4'(i), 1'b0);
    check("bin_up_q", Q, 4'h5);
    check("bin_up_ceo", {3'b0, CEO}, 4'h0);

    // Binary wrap with terminal count, up and down
    load_op("bin_load_e", 4'hE, 4'hE, 1'b0);
    tick("bin_tc_up", 4'hF, 1'b1);
    check("bin_wrap_up_q", Q, 4'h0);
    DIR = 1'b1;
    load_op("bin_load_1", 4'h1, 4'h1, 1'b0);
    tick("bin_tc_dn", 4'h0, 1'b1);
    check("bin_wrap_dn_q", Q, 4'hF);

    // Gray
    mode_op("gray", 2'b01, 1'b0, 4'b0000);
    tick("gray", 4'b0001, 1'b0);
    tick("gray", 4'b0011, 1'b0);
    tick("gray", 4'b0010, 1'b0);
    check("gray_q", Q, 4'b0110);

    // Ring, left then reversed
    mode_op("ring", 2'b10, 1'b0, 4'b0001);
    tick("ring", 4'b0010, 1'b0);
    tick("ring", 4'b0100, 1'b0);
    tick("ring_tc_up", 4'b1000, 1'b1);
    check("ring_wrap_q", Q, 4'b0001);
    DIR = 1'b1;
    tick("ring_tc_dn", 4'b0001, 1'b1);
    tick("ring_dn", 4'b1000, 1'b0);
    check("ring_dn_q", Q, 4'b0100);

    // Ring load clamp: D=9 -> position 3
    load_op("ring_clamp", 4'h9, 4'b1000, 1'b0);
    check("ring_clamp_step_q", Q, 4'b0100);

    // Bounce (DIR ignored)
    mode_op("bounce", 2'b11, 1'b1, 4'b0001);
    tick("bounce", 4'b0010, 1'b0);
    tick("bounce", 4'b0100, 1'b0);
    tick("bounce", 4'b1000, 1'b0);
    tick("bounce", 4'b0100, 1'b0);
    tick("bounce_tc", 4'b0010, 1'b1);
    tick("bounce", 4'b0001, 1'b0);
    check("bounce_q", Q, 4'b0010);

    // EN low freezes prescaler (held at 2) and pattern
    edges(2);
    EN = 1'b0;
    edges(10);
    check("en_freeze_q", Q, 4'b0010);
    check("en_freeze_ceo", {3'b0, CEO}, 4'h0);
    EN = 1'b1;
    push("en_resume", 4'b0010, 1'b0);
    edges(1);
    check("en_resume_ceo", {3'b0, CEO}, 4'h1);
    edges(1);

    // Walk to DN at position 1, then LOAD during the tick that would give TC
    tick("bounce", 4'b0100, 1'b0);
    tick("bounce", 4'b1000, 1'b0);
    tick("bounce", 4'b0100, 1'b0);
    push("load_vs_ceo", 4'b0010, 1'b0);
    edges(3);
    LOAD = 1'b1;
    D    = 4'h3;
    edges(1);
    LOAD = 1'b0;
    check("load_vs_ceo_q", Q, 4'b1000);

    // Async reset between edges while CEO is high
    edges(3);
    check("pre_reset_ceo", {3'b0, CEO}, 4'h1);
    #1;
    CLR_N = 1'b0;
    MODE  = 2'b00;
    DIR   = 1'b0;
    #1;
    check("async_rst_q",   Q,           4'h0);
    check("async_rst_ceo", {3'b0, CEO}, 4'h0);
    check("async_rst_tc",  {3'b0, TC},  4'h0);
    @(negedge C);
    CLR_N = 1'b1;
    push("post_reset", 4'h0, 1'b0);
    edges(2);
    check("post_reset_ceo_early", {3'b0, CEO}, 4'h0);
    edges(1);
    check("post_reset_ceo", {3'b0, CEO}, 4'h1);
    edges(1);
    check("post_reset_q", Q, 4'h1);

    edges(2);
    check("queue_drained", 4'(exp_q.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
